// File: rtl/rewire_react_host_if.sv
// rtl/rewire_react_host_if.sv - valid/ready word stream used for the host input and output sides
interface rewire_react_host_if #(
    parameter int W = 1
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    // Producer drives valid/data, consumer drives ready.
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rewire_react_host.sv
// rtl/rewire_react_host.sv - steps a ReWire reactive device from an input stream and queues its responses
module rewire_react_host #(
    parameter int             IN_W    = 1,
    parameter int             OUT_W   = 1,
    parameter int             DEPTH   = 4,
    parameter logic [IN_W-1:0] IDLE_IN = '0,
    parameter int             CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    rewire_react_host_if.slave  s_if,
    rewire_react_host_if.master m_if,
    output logic              dev_rst_o,
    output logic [IN_W-1:0]   dev_in_o,
    input  logic [OUT_W-1:0]  dev_out_i,
    input  logic              dev_cont_i,
    output logic              running_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycles_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic [CW-1:0]       count_q, count_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]    hold_q, hold_d;
    logic [OUT_W-1:0]    mem_q [DEPTH];

    logic running;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic s_ready;

    // Handshake decode: a pop frees a slot this cycle, so a full FIFO can still accept
    // when the consumer is draining it. s_ready never looks at s_valid.
    always_comb begin
        running    = (state_q == ST_RUN);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        pop        = m_if.ready & ~fifo_empty;
        s_ready    = running & dev_cont_i & (~fifo_full | pop);
        push       = s_if.valid & s_ready;
    end

    // Run-control FSM: device is held in reset outside RUN, so each run begins from
    // the device's initial resumption.
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    cycles_d = '0;
                end
            end
            ST_RUN: begin
                if (cycles_q != CNT_MAX) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (!dev_cont_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    cycles_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response FIFO bookkeeping; hold_q remembers the last popped word so m_data stays
    // stable while the FIFO is empty.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cycles_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // FIFO storage: the device output seen on an accept cycle answers the previous input.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dev_out_i;
        end
    end

    assign s_if.ready = s_ready;
    assign m_if.valid = ~fifo_empty;
    assign m_if.data  = fifo_empty ? hold_q : mem_q[rd_ptr_q];
    assign dev_rst_o  = ~running;
    assign dev_in_o   = push ? s_if.data : IDLE_IN;
    assign running_o  = running;
    assign done_o     = (state_q == ST_DONE);
    assign cycles_o   = cycles_q;
endmodule
